// File: rtl/io_input_capture_if.sv
// io_input_capture_if
//   CPU-side handshake between the control unit and the operator input block.
//   read_request   : one-cycle pulse, execute an IN instruction
//   imported_data  : zero-extended captured switch word
//   data_valid     : one-cycle pulse, imported_data freshly updated
//   input_stall    : high while the core must hold its PC
//   master = control unit / datapath, slave = io_input_capture
interface io_input_capture_if #(
  parameter int DATA_SIZE = 32
);
  logic                 read_request;
  logic [DATA_SIZE-1:0] imported_data;
  logic                 data_valid;
  logic                 input_stall;

  modport master (
    output read_request,
    input  imported_data,
    input  data_valid,
    input  input_stall
  );

  modport slave (
    input  read_request,
    output imported_data,
    output data_valid,
    output input_stall
  );
endinterface

// File: rtl/io_input_capture.sv
// io_input_capture
//   Turns the board slide switches and the ENTER key into a CPU-readable word.
//   An IN request stalls the core until the operator presses and releases ENTER;
//   the debounced switch value seen at the press is returned zero-extended.
// Ports
//   fast_clock   : single clock for all logic
//   reset        : asynchronous active-low reset, release synchronised internally
//   switches     : raw slide switches (asynchronous)
//   enter_button : raw ENTER key, active-high (asynchronous)
//   waiting_led  : mirrors input_stall, drives the operator prompt LED
//   cpu          : slave side of the CPU handshake interface
module io_input_capture #(
  parameter int SWITCH_SIZE     = 16,
  parameter int DATA_SIZE       = 32,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int COUNTER_LEN     = 16
) (
  input  logic                   fast_clock,
  input  logic                   reset,
  input  logic [SWITCH_SIZE-1:0] switches,
  input  logic                   enter_button,
  output logic                   waiting_led,
  io_input_capture_if.slave      cpu
);

  localparam logic [COUNTER_LEN-1:0] CNT_MAX_C = COUNTER_LEN'(DEBOUNCE_CYCLES - 1);
  localparam logic [COUNTER_LEN-1:0] CNT_ONE_C = COUNTER_LEN'(1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2,
    DONE         = 2'd3
  } state_t;

  logic                   rst_meta_r;
  logic                   rst_sync_r;
  logic [SWITCH_SIZE-1:0] sw_meta_r;
  logic [SWITCH_SIZE-1:0] sw_sync_r;
  logic [SWITCH_SIZE-1:0] sw_prev_r;
  logic [COUNTER_LEN-1:0] sw_cnt_r;
  logic [SWITCH_SIZE-1:0] stable_sw_r;
  logic                   btn_meta_r;
  logic                   btn_sync_r;
  logic                   btn_prev_r;
  logic [COUNTER_LEN-1:0] btn_cnt_r;
  logic                   btn_stable_r;
  logic                   btn_stable_d_r;
  logic                   press_evt_s;
  logic                   release_evt_s;
  state_t                 state_r;
  state_t                 next_state_s;
  logic                   capture_s;
  logic [SWITCH_SIZE-1:0] cap_r;
  logic [DATA_SIZE-1:0]   imported_data_r;
  logic                   data_valid_r;
  logic                   input_stall_r;

  // Reset synchroniser: assert immediately, release two clock edges later
  always_ff @(posedge fast_clock or negedge reset) begin
    if (!reset) begin
      rst_meta_r <= 1'b0;
      rst_sync_r <= 1'b0;
    end else begin
      rst_meta_r <= 1'b1;
      rst_sync_r <= rst_meta_r;
    end
  end

  // Two-flop synchronisers for the asynchronous board inputs
  always_ff @(posedge fast_clock or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      sw_meta_r  <= '0;
      sw_sync_r  <= '0;
      btn_meta_r <= 1'b0;
      btn_sync_r <= 1'b0;
    end else begin
      sw_meta_r  <= switches;
      sw_sync_r  <= sw_meta_r;
      btn_meta_r <= enter_button;
      btn_sync_r <= btn_meta_r;
    end
  end

  // Switch debounce: one shared counter for the whole vector. The stable value
  // is only loaded when the vector is also unchanged this cycle, so a single
  // cycle glitch arriving just as the counter saturates is never accepted.
  always_ff @(posedge fast_clock or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      sw_prev_r   <= '0;
      sw_cnt_r    <= '0;
      stable_sw_r <= '0;
    end else begin
      sw_prev_r <= sw_sync_r;
      if (sw_sync_r != sw_prev_r) begin
        sw_cnt_r <= '0;
      end else if (sw_cnt_r != CNT_MAX_C) begin
        sw_cnt_r <= sw_cnt_r + CNT_ONE_C;
      end else begin
        sw_cnt_r <= sw_cnt_r;
      end
      if ((sw_cnt_r == CNT_MAX_C) && (sw_sync_r == sw_prev_r)) begin
        stable_sw_r <= sw_sync_r;
      end else begin
        stable_sw_r <= stable_sw_r;
      end
    end
  end

  // Button debounce, same rule as the switches, plus a delayed copy for edges
  always_ff @(posedge fast_clock or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      btn_prev_r     <= 1'b0;
      btn_cnt_r      <= '0;
      btn_stable_r   <= 1'b0;
      btn_stable_d_r <= 1'b0;
    end else begin
      btn_prev_r     <= btn_sync_r;
      btn_stable_d_r <= btn_stable_r;
      if (btn_sync_r != btn_prev_r) begin
        btn_cnt_r <= '0;
      end else if (btn_cnt_r != CNT_MAX_C) begin
        btn_cnt_r <= btn_cnt_r + CNT_ONE_C;
      end else begin
        btn_cnt_r <= btn_cnt_r;
      end
      if ((btn_cnt_r == CNT_MAX_C) && (btn_sync_r == btn_prev_r)) begin
        btn_stable_r <= btn_sync_r;
      end else begin
        btn_stable_r <= btn_stable_r;
      end
    end
  end

  assign press_evt_s   = btn_stable_r & ~btn_stable_d_r;
  assign release_evt_s = ~btn_stable_r & btn_stable_d_r;

  // Next-state logic; a press only counts once the request has been accepted,
  // so a key already held (or pressed in the request cycle) is ignored
  always_comb begin
    next_state_s = state_r;
    capture_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (cpu.read_request) begin
          next_state_s = WAIT_PRESS;
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT_PRESS: begin
        if (press_evt_s) begin
          next_state_s = WAIT_RELEASE;
          capture_s    = 1'b1;
        end else begin
          next_state_s = WAIT_PRESS;
        end
      end
      WAIT_RELEASE: begin
        if (release_evt_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = WAIT_RELEASE;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register, capture register and registered outputs
  always_ff @(posedge fast_clock or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      state_r         <= IDLE;
      cap_r           <= '0;
      imported_data_r <= '0;
      data_valid_r    <= 1'b0;
      input_stall_r   <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      input_stall_r <= (next_state_s == WAIT_PRESS) || (next_state_s == WAIT_RELEASE);
      data_valid_r  <= (next_state_s == DONE);
      if (capture_s) begin
        cap_r <= stable_sw_r;
      end else begin
        cap_r <= cap_r;
      end
      // DONE is only entered from WAIT_RELEASE, so cap_r is already settled here
      if ((next_state_s == DONE) && (state_r != DONE)) begin
        imported_data_r <= {{(DATA_SIZE - SWITCH_SIZE){1'b0}}, cap_r};
      end else begin
        imported_data_r <= imported_data_r;
      end
    end
  end

  assign cpu.imported_data = imported_data_r;
  assign cpu.data_valid    = data_valid_r;
  assign cpu.input_stall   = input_stall_r;
  assign waiting_led       = input_stall_r;

endmodule

// File: tb/tb_io_input_capture.sv
// tb_io_input_capture
//   Directed bench for io_input_capture with DEBOUNCE_CYCLES=4. A behavioural
//   model predicts the CPU-visible outputs each cycle; literal checks pin the
//   key results of each scenario.
module tb_io_input_capture;

  localparam int DC = 4;

  logic        fast_clock = 1'b0;
  logic        reset;
  logic [15:0] switches;
  logic        enter_button;
  logic        waiting_led;

  io_input_capture_if #(.DATA_SIZE(32)) cpu_if ();

  io_input_capture #(
    .SWITCH_SIZE(16), .DATA_SIZE(32), .DEBOUNCE_CYCLES(DC), .COUNTER_LEN(16)
  ) dut (
    .fast_clock   (fast_clock),
    .reset        (reset),
    .switches     (switches),
    .enter_button (enter_button),
    .waiting_led  (waiting_led),
    .cpu          (cpu_if.slave)
  );

  always #5 fast_clock = ~fast_clock;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An input is accepted once the synchronised value has been seen on DC+1
  // consecutive cycles; the request is a sequence of phases the operator walks.
  localparam int PH_IDLE = 0, PH_PRESS = 1, PH_RELEASE = 2, PH_DONE = 3;

  logic [15:0] m_sw_s1;
  logic [15:0] m_sw_hist [DC+1];
  logic        m_btn_s1;
  logic        m_btn_hist [DC+1];
  logic [15:0] m_sw_stable;
  logic        m_btn_stable, m_btn_was;
  int          m_phase;
  logic [15:0] m_cap;
  logic [31:0] m_data;
  int          m_rst_age;

  task automatic model_clear();
    m_sw_s1 = '0; m_btn_s1 = 1'b0;
    for (int i = 0; i <= DC; i++) begin
      m_sw_hist[i] = '0; m_btn_hist[i] = 1'b0;
    end
    m_sw_stable = '0; m_btn_stable = 1'b0; m_btn_was = 1'b0;
    m_phase = PH_IDLE; m_cap = '0; m_data = '0;
  endtask

  // Predict the state after the next rising edge from the inputs now applied
  task automatic model_step();
    bit   sw_same, btn_same, pressed, released;
    logic [15:0] new_sw;
    logic new_btn;
    if (m_rst_age < 2) begin
      m_rst_age++;
      return;
    end
    pressed  = m_btn_stable && !m_btn_was;
    released = !m_btn_stable && m_btn_was;
    case (m_phase)
      PH_IDLE:    if (cpu_if.read_request) m_phase = PH_PRESS;
      PH_PRESS:   if (pressed) begin m_cap = m_sw_stable; m_phase = PH_RELEASE; end
      PH_RELEASE: if (released) begin m_data = {16'h0000, m_cap}; m_phase = PH_DONE; end
      default:    m_phase = PH_IDLE;
    endcase
    sw_same = 1'b1; btn_same = 1'b1;
    for (int i = 1; i <= DC; i++) begin
      if (m_sw_hist[i] != m_sw_hist[0]) sw_same = 1'b0;
      if (m_btn_hist[i] != m_btn_hist[0]) btn_same = 1'b0;
    end
    new_sw  = sw_same  ? m_sw_hist[0]  : m_sw_stable;
    new_btn = btn_same ? m_btn_hist[0] : m_btn_stable;
    m_sw_stable  = new_sw;
    m_btn_was    = m_btn_stable;
    m_btn_stable = new_btn;
    for (int i = DC; i >= 1; i--) begin
      m_sw_hist[i] = m_sw_hist[i-1]; m_btn_hist[i] = m_btn_hist[i-1];
    end
    m_sw_hist[0] = m_sw_s1; m_btn_hist[0] = m_btn_s1;
    m_sw_s1 = switches; m_btn_s1 = enter_button;
  endtask

  // Compare process: outputs after each rising edge are checked at the falling edge
  initial begin
    model_clear();
    m_rst_age = 0;
    forever begin
      @(negedge fast_clock);
      if (!reset) begin
        model_clear();
        m_rst_age = 0;
      end
      chk("stall", {31'd0, cpu_if.input_stall}, {31'd0, (m_phase == PH_PRESS) || (m_phase == PH_RELEASE)});
      chk("led",   {31'd0, waiting_led},        {31'd0, (m_phase == PH_PRESS) || (m_phase == PH_RELEASE)});
      chk("valid", {31'd0, cpu_if.data_valid},  {31'd0, m_phase == PH_DONE});
      chk("data",  cpu_if.imported_data,        m_data);
      if (cpu_if.data_valid) n_valid++;
      if (reset) model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge fast_clock);
    #2;
  endtask

  task automatic request();
    cpu_if.read_request = 1'b1;
    tick(1);
    cpu_if.read_request = 1'b0;
  endtask

  task automatic press_release(input int hold, input int after);
    enter_button = 1'b1;
    tick(hold);
    enter_button = 1'b0;
    tick(after);
  endtask

  initial begin
    reset = 1'b1;
    switches = 16'hA5A5;
    enter_button = 1'b0;
    cpu_if.read_request = 1'b0;
    #1 reset = 1'b0;
    tick(3);
    chk("rst_stall", {31'd0, cpu_if.input_stall}, 32'd0);
    chk("rst_data",  cpu_if.imported_data, 32'h0000_0000);
    reset = 1'b1;
    tick(12);

    // 1: basic capture
    n_valid = 0;
    request();
    tick(2);
    chk("t1_stall", {31'd0, cpu_if.input_stall}, 32'd1);
    press_release(10, 12);
    chk("t1_data",  cpu_if.imported_data, 32'h0000_A5A5);
    chk("t1_model", m_data, 32'h0000_A5A5);
    chk("t1_pulses", n_valid, 32'd1);
    chk("t1_idle", {31'd0, cpu_if.input_stall}, 32'd0);

    // 2: bouncing ENTER gives a single capture
    switches = 16'h3C3C;
    tick(10);
    n_valid = 0;
    request();
    tick(2);
    for (int i = 0; i < 3; i++) begin
      enter_button = 1'b1; tick(2);
      enter_button = 1'b0; tick(2);
    end
    press_release(12, 12);
    chk("t2_data", cpu_if.imported_data, 32'h0000_3C3C);
    chk("t2_pulses", n_valid, 32'd1);

    // 3: press without a request does nothing
    n_valid = 0;
    switches = 16'h7777;
    press_release(12, 12);
    chk("t3_data", cpu_if.imported_data, 32'h0000_3C3C);
    chk("t3_pulses", n_valid, 32'd0);

    // 4: switch change after the press does not alter the capture
    switches = 16'h0001;
    tick(10);
    n_valid = 0;
    request();
    tick(2);
    enter_button = 1'b1;
    tick(10);
    switches = 16'hFFFF;
    tick(10);
    enter_button = 1'b0;
    tick(12);
    chk("t4_data", cpu_if.imported_data, 32'h0000_0001);
    chk("t4_pulses", n_valid, 32'd1);

    // 5: reset while waiting for the press
    switches = 16'h1234;
    request();
    tick(3);
    chk("t5_stall_pre", {31'd0, cpu_if.input_stall}, 32'd1);
    reset = 1'b0;
    tick(3);
    chk("t5_stall_rst", {31'd0, cpu_if.input_stall}, 32'd0);
    chk("t5_data_rst", cpu_if.imported_data, 32'h0000_0000);
    reset = 1'b1;
    tick(12);
    n_valid = 0;
    request();
    tick(2);
    press_release(10, 12);
    chk("t5_data", cpu_if.imported_data, 32'h0000_1234);
    chk("t5_pulses", n_valid, 32'd1);

    // 6: key held at request time, plus a redundant request during the stall
    switches = 16'h5A5A;
    enter_button = 1'b1;
    tick(12);
    n_valid = 0;
    request();
    tick(8);
    chk("t6_stall_held", {31'd0, cpu_if.input_stall}, 32'd1);
    request();
    tick(2);
    enter_button = 1'b0;
    tick(10);
    chk("t6_stall_rel", {31'd0, cpu_if.input_stall}, 32'd1);
    chk("t6_no_pulse", n_valid, 32'd0);
    press_release(10, 12);
    chk("t6_data", cpu_if.imported_data, 32'h0000_5A5A);
    chk("t6_pulses", n_valid, 32'd1);
    tick(6);
    chk("t6_no_queue", {31'd0, cpu_if.input_stall}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
